// File: rtl/cfg_dispatch_pkg.sv
// Shared definitions for the config-word dispatcher: word fields, FSM encoding
// and error cause codes.
package cfg_dispatch_pkg;

  localparam int TID_MSB  = 31;
  localparam int TID_LSB  = 24;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Kept as a cause code rather than a flag so status readback can be added later.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BADTGT  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_cause_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cfg_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_ptr and wraps.
// Returns a one-hot grant and the encoded winner index.
module cfg_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);
  localparam int PW = $clog2(NUM_REQ);

  int   w_pos;
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      // Compare against each position instead of indexing with a run-time int.
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && i_req[j] && (j == w_pos)) begin
          w_found    = 1'b1;
          o_grant[j] = 1'b1;
          o_idx      = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cfg_dispatch.sv
// Arbitrates config words from several requesters and issues one target register
// write each. States: IDLE wait/grant | ISSUE strobe | WAIT ack or timeout | RESP pulse.
module cfg_dispatch
  import cfg_dispatch_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_TGT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_done,
  output logic [NUM_REQ-1:0]     rsp_err,
  output logic [NUM_TGT-1:0]     tgt_wr,
  output logic [7:0]             tgt_addr,
  output logic [15:0]            tgt_wdata,
  input  logic [NUM_TGT-1:0]     tgt_ack,
  output logic                   busy,
  output logic [7:0]             err_count
);
  localparam int PW = $clog2(NUM_REQ);

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_ptr, r_win, w_win, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_grant, w_win_oh;
  logic [31:0]        r_word, w_word;
  err_cause_t         r_err;
  logic [16:0]        r_cnt, w_cnt_inc;
  logic [7:0]         r_err_count, w_tid;
  logic [NUM_TGT-1:0] w_sel;
  logic               w_tid_ok, w_ack, w_timeout;

  cfg_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win)
  );

  always_comb begin
    w_tid  = r_word[TID_MSB:TID_LSB];
    w_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == PW'(i)) w_word = req_data[32*i +: 32];
    end
    w_sel = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      w_sel[t] = (w_tid == 8'(t));
    end
    w_tid_ok  = |w_sel;
    // Only the addressed target's ack counts.
    w_ack     = |(tgt_ack & w_sel);
    w_cnt_inc = r_cnt + 17'd1;
    w_timeout = (w_cnt_inc == 17'(TIMEOUT));
    w_win_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_oh[i] = (r_win == PW'(i));
    end
    w_ptr_nxt = (int'(r_win) == NUM_REQ - 1) ? '0 : r_win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_word      <= '0;
      r_err       <= ERR_NONE;
      r_cnt       <= '0;
      r_err_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: if (|req_valid) begin
          r_word <= w_word;
          r_win  <= w_win;
          r_err  <= ERR_NONE;
        end
        ST_ISSUE: begin
          r_cnt <= '0;
          if (!w_tid_ok) r_err <= ERR_BADTGT;
        end
        ST_WAIT: if (!w_ack) begin
          r_cnt <= w_cnt_inc;
          if (w_timeout) r_err <= ERR_TIMEOUT;
        end
        ST_RESP: begin
          r_ptr <= w_ptr_nxt;
          if (r_err != ERR_NONE) r_err_count <= sat_inc8(r_err_count);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (|req_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = w_tid_ok ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (w_ack || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    tgt_wr    = '0;
    rsp_done  = '0;
    rsp_err   = '0;
    if (r_state == ST_IDLE && !rst) req_ready = w_grant;
    if (r_state == ST_ISSUE) tgt_wr = w_sel;
    if (r_state == ST_RESP) begin
      rsp_done = w_win_oh;
      rsp_err  = (r_err != ERR_NONE) ? w_win_oh : '0;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign tgt_addr  = r_word[ADDR_MSB:ADDR_LSB];
  assign tgt_wdata = r_word[DATA_MSB:DATA_LSB];
  assign err_count = r_err_count;

endmodule

// File: tb/tb_cfg_dispatch.sv
// Self-checking bench for cfg_dispatch: directed table, reset and round-robin
// sequences, random traffic against a transaction-level latency model, saturation.
module tb_cfg_dispatch;
  localparam int NR = 2;
  localparam int NT = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  tgt_ack = '0;
  logic [1:0]  req_ready, rsp_done, rsp_err;
  logic [3:0]  tgt_wr;
  logic [7:0]  tgt_addr;
  logic [15:0] tgt_wdata;
  logic        busy;
  logic [7:0]  err_count;

  cfg_dispatch #(.NUM_REQ(NR), .NUM_TGT(NT), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_done  (rsp_done),
    .rsp_err   (rsp_err),
    .tgt_wr    (tgt_wr),
    .tgt_addr  (tgt_addr),
    .tgt_wdata (tgt_wdata),
    .tgt_ack   (tgt_ack),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [31:0] word;
    int          d;
    bit          noise;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t        tbl[8];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          m_ptr = 0;
  int          m_errcnt = 0;
  logic [1:0]  g_last;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int r);
    return (r == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] qfront(input int r);
    if (qsize(r) == 0) return 32'h0;
    return (r == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int r, input logic [31:0] w);
    if (r == 0) q0.push_back(w);
    else q1.push_back(w);
  endtask

  task automatic qpop(input int r);
    if (r == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic refresh();
    req_valid[0]    = (q0.size() > 0);
    req_valid[1]    = (q1.size() > 0);
    req_data[31:0]  = qfront(0);
    req_data[63:32] = qfront(1);
    #1;
  endtask

  // Ack in WAIT cycle d (1 = first WAIT cycle) is accepted if d <= TO.
  task automatic model_rsp(input logic [31:0] w, input int d, output bit err, output int lat);
    if (int'(w[31:24]) >= NT) begin
      err = 1'b1; lat = 1;
    end else if (d <= TO) begin
      err = 1'b0; lat = d + 1;
    end else begin
      err = 1'b1; lat = TO + 1;
    end
  endtask

  task automatic run_one(input int d, input bit noise, input bit use_exp,
                         input bit t_err, input int t_lat);
    int          r;
    int          waited;
    int          got_lat;
    bit          got_err;
    bit          extra;
    bit          e_err;
    int          e_lat;
    logic [31:0] w;
    logic [3:0]  oh;
    r = -1;
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (m_ptr + k) % NR;
      if (r < 0 && qsize(c) > 0) r = c;
    end
    if (r < 0) return;
    w = qfront(r);
    model_rsp(w, d, e_err, e_lat);
    if (use_exp) begin
      e_err = t_err;
      e_lat = t_lat;
    end
    waited = 0;
    while (req_ready == 2'b00 && waited < 20) begin
      step();
      waited++;
    end
    chk("ready_grant", {30'b0, req_ready}, 32'(1 << r));
    g_last = req_ready;
    if (req_ready == 2'b00) return;
    step();
    qpop(r);
    refresh();
    oh = (int'(w[31:24]) < NT) ? 4'(1 << w[25:24]) : 4'b0;
    chk("strobe", {28'b0, tgt_wr}, {28'b0, oh});
    chk("addr", {24'b0, tgt_addr}, {24'b0, w[23:16]});
    chk("wdata", {16'b0, tgt_wdata}, {16'b0, w[15:0]});
    chk("busy_issue", {31'b0, busy}, 32'd1);
    if (noise && oh != 4'b0) tgt_ack = oh;
    got_lat = -1;
    got_err = 1'b0;
    extra   = 1'b0;
    for (int j = 1; j <= TO + 4; j++) begin
      step();
      if (tgt_wr != 4'b0) extra = 1'b1;
      if (rsp_done != 2'b00) begin
        got_lat = j;
        got_err = |rsp_err;
        chk("done_dest", {30'b0, rsp_done}, 32'(1 << r));
        chk("err_dest", {30'b0, rsp_err}, e_err ? 32'(1 << r) : 32'd0);
        break;
      end
      if (j == d) tgt_ack = oh;
      else if (noise && oh != 4'b0) tgt_ack = {oh[2:0], oh[3]};
      else tgt_ack = 4'b0;
    end
    tgt_ack = 4'b0;
    chk("latency", 32'(got_lat), 32'(e_lat));
    chk("err_flag", {31'b0, got_err}, {31'b0, e_err});
    chk("no_extra_strobe", {31'b0, extra}, 32'd0);
    if (e_err && m_errcnt < 255) m_errcnt++;
    m_ptr = (r + 1) % NR;
    step();
    chk("pulse_one_cycle", {30'b0, rsp_done}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    chk("err_count", {24'b0, err_count}, 32'(m_errcnt));
  endtask

  initial begin
    int waited;
    int rr_exp[6];

    tbl[0] = '{0, 32'h0112ABCD, 2,  1'b0, 1'b0, 3};
    tbl[1] = '{1, 32'h07000001, 1,  1'b0, 1'b1, 1};
    tbl[2] = '{0, 32'h00445566, 99, 1'b0, 1'b1, 9};
    tbl[3] = '{0, 32'h00AA0001, 8,  1'b1, 1'b0, 9};
    tbl[4] = '{1, 32'h03FF1234, 1,  1'b1, 1'b0, 2};
    tbl[5] = '{0, 32'h02010203, 9,  1'b0, 1'b1, 9};
    tbl[6] = '{1, 32'h04000000, 1,  1'b0, 1'b1, 1};
    tbl[7] = '{0, 32'hFF000000, 1,  1'b0, 1'b1, 1};
    rr_exp = '{1, 2, 1, 2, 1, 2};

    // Reset state, with requests pending to show ready stays low under reset.
    rst = 1'b1;
    req_valid = 2'b11;
    step();
    step();
    chk("rst_ready", {30'b0, req_ready}, 32'd0);
    chk("rst_done", {30'b0, rsp_done}, 32'd0);
    chk("rst_err", {30'b0, rsp_err}, 32'd0);
    chk("rst_wr", {28'b0, tgt_wr}, 32'd0);
    chk("rst_addr", {24'b0, tgt_addr}, 32'd0);
    chk("rst_wdata", {16'b0, tgt_wdata}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_errcnt", {24'b0, err_count}, 32'd0);
    refresh();
    rst = 1'b0;
    step();

    // Round-robin with both requesters continuously valid.
    qpush(0, 32'h00010001); qpush(0, 32'h01020002); qpush(0, 32'h02030003);
    qpush(1, 32'h03040004); qpush(1, 32'h00050005); qpush(1, 32'h01060006);
    refresh();
    for (int i = 0; i < 6; i++) begin
      run_one(1, 1'b1, 1'b0, 1'b0, 0);
      chk("rr_order", {30'b0, g_last}, 32'(rr_exp[i]));
    end

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      qpush(tbl[i].r, tbl[i].word);
      refresh();
      run_one(tbl[i].d, tbl[i].noise, 1'b1, tbl[i].exp_err, tbl[i].exp_lat);
    end

    // Reset three cycles after the strobe, then a stale ack, then a clean write.
    qpush(0, 32'h02340055);
    refresh();
    waited = 0;
    while (req_ready == 2'b00 && waited < 20) begin
      step();
      waited++;
    end
    chk("mid_ready", {30'b0, req_ready}, 32'd1);
    step();
    qpop(0);
    refresh();
    chk("mid_strobe", {28'b0, tgt_wr}, 32'h4);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {30'b0, rsp_done}, 32'd0);
    chk("mid_rst_wr", {28'b0, tgt_wr}, 32'd0);
    chk("mid_rst_addr", {24'b0, tgt_addr}, 32'd0);
    chk("mid_rst_wdata", {16'b0, tgt_wdata}, 32'd0);
    chk("mid_rst_errcnt", {24'b0, err_count}, 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    m_errcnt = 0;
    tgt_ack = 4'b0100;
    step();
    chk("late_ack_done", {30'b0, rsp_done}, 32'd0);
    step();
    chk("late_ack_busy", {31'b0, busy}, 32'd0);
    tgt_ack = 4'b0;
    qpush(1, 32'h02340056);
    refresh();
    run_one(3, 1'b0, 1'b1, 1'b0, 4);

    // Random traffic against the latency model.
    for (int i = 0; i < 40; i++) begin
      int n;
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++)
        qpush($urandom_range(0, 1), {8'($urandom_range(0, 5)), 24'($urandom)});
      if (qsize(0) + qsize(1) == 0)
        qpush($urandom_range(0, 1), {8'($urandom_range(0, 5)), 24'($urandom)});
      refresh();
      run_one($urandom_range(1, 11), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);
    end
    for (int i = 0; i < 100 && (qsize(0) + qsize(1)) > 0; i++)
      run_one($urandom_range(1, 11), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      qpush(1, 32'h09000000 | 32'(i));
      refresh();
      run_one(1, 1'b0, 1'b0, 1'b0, 0);
    end
    chk("err_count_sat", {24'b0, err_count}, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_dispatch.md
Name: cfg_dispatch

Overview:
- Arbitrates 32-bit configuration words from NUM_REQ requesters, e.g. the PC command parser (req 0) and the on-chip init sequencer (req 1).
- Decodes each word and issues one register write to one of NUM_TGT target blocks.
- Waits for the target's acknowledge, with a timeout.
- Returns a done/error pulse to the originating requester.
- Sits between the config word sources and the per-block register files.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- NUM_TGT, 4, number of write targets (1..16)
- TIMEOUT, 255, maximum cycles to wait for tgt_ack before declaring an error (1..65535)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*32  per-requester word, requester i in bits [32i+31:32i]
- req_ready  out  NUM_REQ  one-hot accept, combinational from state and req_valid
- rsp_done  out  NUM_REQ  one-cycle completion pulse to the originating requester
- rsp_err  out  NUM_REQ  qualifies rsp_done: 1 = bad target id or timeout
- tgt_wr  out  NUM_TGT  one-hot one-cycle write strobe
- tgt_addr  out  8  register address
- tgt_wdata  out  16  register write data
- tgt_ack  in  NUM_TGT  per-target write acknowledge
- busy  out  1  high in any state other than IDLE
- err_count  out  8  saturating count of errored transactions

Behaviour:
- Word format: [31:24] target id, [23:16] register address, [15:0] write data.
- Reset: all of the following go to 0 on the next clk edge while rst=1: state IDLE, rr pointer, req_ready, rsp_done, rsp_err, tgt_wr, tgt_addr, tgt_wdata, busy, err_count.
- Reset mid-transaction drops the transaction with no rsp_done. A late tgt_ack arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant round-robin starting at the rr pointer.
  - req_ready[winner] is high in that cycle (cycle T). The word and the winner index are latched at the T edge, then go to ISSUE.
  - Only the winner sees ready. All other requesters keep valid and data stable until their own ready.
- ISSUE (T+1):
  - If target id >= NUM_TGT: no strobe, set error flag, go to RESP.
  - Otherwise: tgt_wr[id]=1 for exactly this cycle, clear the timeout counter, go to WAIT.
  - tgt_addr and tgt_wdata are driven from ISSUE through WAIT and stay stable.
- WAIT:
  - tgt_ack is sampled only in WAIT, and only the bit for the addressed target. Acks from other targets and acks in ISSUE are ignored.
  - Earliest ack is T+2.
  - On ack: go to RESP with ok.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, go to RESP with error.
  - Ack in the same cycle the counter reaches TIMEOUT: the ack wins and the result is ok.
- RESP (one cycle):
  - rsp_done[winner]=1, and rsp_err[winner]=error flag.
  - err_count increments on error and saturates at 255.
  - rr pointer becomes (winner+1) mod NUM_REQ. Go to IDLE.
- Latency:
  - Accept to strobe: 1 cycle.
  - Ack to rsp_done: 1 cycle.
  - Bad-id word: rsp_done at T+2.
  - Back-to-back throughput: one word per 4 cycles minimum (ack at T+2).
- Round-robin priority search order: pointer, pointer+1, ... with wrap. With a single requester continuously valid, it is served every transaction.

Decomposition:
- Shared package cfg_dispatch_pkg holds:
  - word field positions/widths (TID_MSB/LSB, ADDR_MSB/LSB, DATA_MSB/LSB)
  - FSM state encoding
  - error cause codes (ERR_NONE, ERR_BADTGT, ERR_TIMEOUT), for future status readback
- One sub-module, cfg_rr_arbiter:
  - inputs: NUM_REQ request vector, pointer
  - outputs: one-hot grant, encoded winner index
  - purely combinational, reusable by other config paths

Test Plan:
- Reset mid-WAIT: rst asserted 3 cycles after tgt_wr -> all outputs 0 next edge. A later tgt_ack[2] is ignored. A new req then completes normally.
- Single write: req0 sends 0x0112ABCD; tgt1 acks 2 cycles after strobe -> tgt_wr=4'b0010 at T+1 with addr 0x12, data 0xABCD; rsp_done[0]=1, rsp_err[0]=0 the cycle after ack; busy=0 after.
- Bad target: req1 sends 0x07000001 with NUM_TGT=4 -> no tgt_wr; rsp_done[1]=1, rsp_err[1]=1 at T+2; err_count=1.
- Timeout: TIMEOUT=8, target 0 never acks -> rsp_err[0]=1 after 8 WAIT cycles. Case where ack arrives exactly at the count-8 cycle -> rsp_err=0.
- Round-robin: req0 and req1 valid continuously with 3 words each, targets acking immediately -> grant order 0,1,0,1,0,1; each rsp_done goes only to its originator; wrong-target acks injected during WAIT are ignored.
- Saturation: 260 bad-id words -> err_count stops at 255, and rsp_err still pulses for each word.
